// File: rtl/product_accumulator_pkg.sv
// Shared defaults and FSM state encodings for the product accumulator.
package product_accumulator_pkg;

   localparam int unsigned DefaultN    = 32;
   localparam int unsigned DefaultLenW = 8;
   localparam int unsigned DefaultAccW = 2 * DefaultN + DefaultLenW;

   typedef logic [1:0] state_t;

   // Plain constants keep the encoding visible to legacy tooling.
   localparam state_t StIdle = 2'd0;
   localparam state_t StAcc  = 2'd1;
   localparam state_t StDone = 2'd2;

endpackage

// File: rtl/term_counter.sv
// Loadable down-counter tracking how many products are still owed to the current run.
module term_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             is_one_o
);

   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   // Load wins over decrement; the FSM never asserts both together.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i) begin
         count_d = count_q - Width'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flags the final outstanding term so the FSM can leave ACC on that handshake.
   always_comb begin
      is_one_o = (count_q == Width'(1));
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums a requested number of unsigned products streamed from an array multiplier and
// holds the total until the downstream consumer takes it.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int unsigned N     = DefaultN,
   parameter int unsigned LEN_W = DefaultLenW,
   parameter int unsigned ACC_W = 2 * N + LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             p_valid,
   input  logic [2*N-1:0]   p_data,
   output logic             p_ready,
   output logic             acc_valid,
   output logic [ACC_W-1:0] acc_data,
   input  logic             acc_ready,
   output logic             busy
);

   state_t           state_q;
   state_t           state_d;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_is_one;

   term_counter #(
      .Width (LEN_W)
   ) u_term_counter (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .load_val_i (len),
      .dec_i      (cnt_dec),
      .is_one_o   (cnt_is_one)
   );

   // Next-state, accumulator update and counter control.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               acc_d = '0;
               if (len != '0) begin
                  cnt_load = 1'b1;
                  state_d  = StAcc;
               end else begin
                  // An empty run still produces a (zero) result for the consumer.
                  state_d = StDone;
               end
            end
         end
         StAcc: begin
            // p_ready is high throughout ACC, so p_valid alone marks a handshake.
            if (p_valid) begin
               acc_d   = acc_q + ACC_W'(p_data);
               cnt_dec = 1'b1;
               if (cnt_is_one) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (acc_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and accumulator registers; reset discards any product on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   // Handshake and status outputs decode the state register only.
   always_comb begin
      p_ready   = (state_q == StAcc);
      acc_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      acc_data  = acc_q;
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed table, corner sequences and random runs.
module tb_product_accumulator;

   localparam int unsigned N     = 32;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned ACC_W = 72;
   localparam int          NV    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             p_valid;
   logic [2*N-1:0]   p_data;
   logic             p_ready;
   logic             acc_valid;
   logic [ACC_W-1:0] acc_data;
   logic             acc_ready;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [LEN_W-1:0] len;
      logic [2*N-1:0]   p [4];
      logic [ACC_W-1:0] exp;
   } vec_t;

   vec_t vecs [NV];

   product_accumulator #(
      .N     (N),
      .LEN_W (LEN_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .p_valid   (p_valid),
      .p_data    (p_data),
      .p_ready   (p_ready),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .acc_ready (acc_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [ACC_W-1:0] act,
                            input logic [ACC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [LEN_W-1:0] l, input logic [2*N-1:0] a,
                          input logic [2*N-1:0] b, input logic [2*N-1:0] c,
                          input logic [2*N-1:0] d, input logic [ACC_W-1:0] e);
      vecs[i].len  = l;
      vecs[i].p[0] = a;
      vecs[i].p[1] = b;
      vecs[i].p[2] = c;
      vecs[i].p[3] = d;
      vecs[i].exp  = e;
   endtask

   // One complete run: start, feed products with random idle gaps, check and drain result.
   task automatic run(input string name, input logic [LEN_W-1:0] l, input logic [2*N-1:0] prods[$],
                      input int gap_max, input logic [ACC_W-1:0] exp);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      check_bit({name, ":busy"}, busy, 1'b1);
      check_bit({name, ":p_ready"}, p_ready, (l != 0));
      foreach (prods[i]) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         checks++;
         if (p_ready !== 1'b1 || acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s:accept_state term %0d: p_ready=%b acc_valid=%b want 1/0",
                     name, i, p_ready, acc_valid);
            return;
         end
         p_valid = 1'b1;
         p_data  = prods[i];
         tick();
         p_valid = 1'b0;
         p_data  = $urandom;
      end
      check_bit({name, ":acc_valid"}, acc_valid, 1'b1);
      check_bit({name, ":p_ready_done"}, p_ready, 1'b0);
      check_val({name, ":acc_data"}, acc_data, exp);
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      check_bit({name, ":idle_after"}, busy, 1'b0);
   endtask

   initial begin
      logic [2*N-1:0]   q [$];
      logic [ACC_W-1:0] model_sum;
      logic [ACC_W-1:0] held;
      logic [LEN_W-1:0] rl;

      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      p_valid   = 1'b0;
      p_data    = '0;
      acc_ready = 1'b0;
      tick();
      tick();
      check_bit("reset:p_ready", p_ready, 1'b0);
      check_bit("reset:acc_valid", acc_valid, 1'b0);
      check_bit("reset:busy", busy, 1'b0);
      check_val("reset:acc_data", acc_data, 72'd0);
      rst = 1'b0;
      tick();

      set_vec(0, 8'd3, 64'd5, 64'd7, 64'd9, 64'd0, 72'd21);
      set_vec(1, 8'd0, 64'd0, 64'd0, 64'd0, 64'd0, 72'd0);
      set_vec(2, 8'd1, 64'd42, 64'd0, 64'd0, 64'd0, 72'd42);
      set_vec(3, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 72'h1_0000_0000_0000_0000);
      set_vec(4, 8'd4, 64'd1000, 64'd2000, 64'd3000, 64'd4000, 72'd10000);
      for (int i = 0; i < NV; i++) begin
         q.delete();
         for (int k = 0; k < int'(vecs[i].len); k++) q.push_back(vecs[i].p[k]);
         run($sformatf("vec%0d", i), vecs[i].len, q, 0, vecs[i].exp);
      end

      // Worst case width: 255 maximal products with random valid gaps.
      q.delete();
      for (int k = 0; k < 255; k++) q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      run("max255", 8'd255, q, 3, 72'hFE_FFFF_FFFF_FFFF_FF01);

      // DONE must hold while the consumer stalls, ignoring start and stray products.
      q.delete();
      q.push_back(64'd11);
      q.push_back(64'd22);
      start = 1'b1;
      len   = 8'd2;
      tick();
      start = 1'b0;
      foreach (q[i]) begin
         p_valid = 1'b1;
         p_data  = q[i];
         tick();
      end
      p_valid = 1'b0;
      held = 72'd33;
      for (int c = 0; c < 3; c++) begin
         start   = 1'b1;
         len     = 8'd5;
         p_valid = 1'b1;
         p_data  = 64'd1000;
         tick();
         check_val($sformatf("stall%0d:acc_data", c), acc_data, held);
         check_bit($sformatf("stall%0d:acc_valid", c), acc_valid, 1'b1);
         check_bit($sformatf("stall%0d:p_ready", c), p_ready, 1'b0);
      end
      start     = 1'b0;
      p_valid   = 1'b0;
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      check_bit("stall:idle_after", busy, 1'b0);
      tick();
      check_bit("stall:no_new_run", busy, 1'b0);

      // Reset in the middle of a run, with a product offered on the reset edge.
      start = 1'b1;
      len   = 8'd4;
      tick();
      start   = 1'b0;
      p_valid = 1'b1;
      p_data  = 64'd10;
      tick();
      p_data = 64'd20;
      tick();
      rst    = 1'b1;
      p_data = 64'd99;
      tick();
      rst     = 1'b0;
      p_valid = 1'b0;
      check_bit("midrst:busy", busy, 1'b0);
      check_bit("midrst:p_ready", p_ready, 1'b0);
      check_val("midrst:acc_data", acc_data, 72'd0);
      q.delete();
      q.push_back(64'd42);
      run("after_rst", 8'd1, q, 0, 72'd42);

      // Random runs against a plain sum-of-queue model.
      for (int r = 0; r < 20; r++) begin
         rl = LEN_W'($urandom_range(12, 0));
         q.delete();
         model_sum = '0;
         for (int k = 0; k < int'(rl); k++) begin
            q.push_back({$urandom, $urandom});
            model_sum = model_sum + {8'd0, q[k]};
         end
         run($sformatf("rand%0d", r), rl, q, 2, model_sum);
         repeat ($urandom_range(2, 0)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
